// File: rtl/game_pkg.sv
// game_pkg: grid geometry, RGB111 colour names and FSM state encoding for the cell-painting game
package game_pkg;
  localparam int AW = 8;
  localparam int DW = 3;
  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int CELLS = GRID_W * GRID_H;
  typedef enum logic [DW-1:0] {BLACK = 3'b000, RED = 3'b100, GREEN = 3'b010, BLUE = 3'b001} colour_t;
  typedef enum logic [1:0] {CLEAR, DRAW, IDLE} state_t;
endpackage

// File: rtl/game_paint_fsm_if.sv
// game_paint_fsm_if: frame-buffer write port driven by the game controller
interface game_paint_fsm_if;
  import game_pkg::*;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic px_wr;
  modport master (output mem_px_addr, output mem_px_data, output px_wr);
  modport slave (input mem_px_addr, input mem_px_data, input px_wr);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, optional debounce filter (GAME_DEBOUNCE_EN), rising-edge pulse
module btn_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pls
);
  logic [1:0] sync;
  logic lvl, prev;
  always_ff @(posedge clk) sync <= rst ? 2'b00 : {sync[0], btn};
`ifdef GAME_DEBOUNCE_EN
  localparam int DEBOUNCE_CYCLES = 750000;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt;
  logic filt;
  // the filtered level follows only after the new level has held for the full window
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      filt <= 1'b0;
    end else if (sync[1] == filt) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      filt <= sync[1];
    end else cnt <= cnt + 1'b1;
  assign lvl = filt;
`else
  assign lvl = sync[1];
`endif
  always_ff @(posedge clk) prev <= rst ? 1'b0 : lvl;
  assign pls = lvl & ~prev;
endmodule

// File: rtl/game_paint_fsm.sv
// game_paint_fsm: cursor/paint controller writing RGB111 cells of a 16x12 grid into the frame buffer
// Define GAME_DEBOUNCE_EN to debounce the buttons before edge detection.
module game_paint_fsm
  import game_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in1,
  input  logic                 in2,
  input  logic [DW-1:0]        switch,
  input  logic                 clr,
  game_paint_fsm_if.master     fb
);
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
  state_t state, nxt;
  logic [AW-1:0] cnt, cursor, cursor_nxt, addr_d;
  logic [DW-1:0] last_col, data_d;
  logic [1:0] clr_sync;
  logic r_pls, l_pls, wr_d;
  btn_conditioner u_right (.clk(clk), .rst(rst), .btn(in1), .pls(r_pls));
  btn_conditioner u_left (.clk(clk), .rst(rst), .btn(in2), .pls(l_pls));
  always_ff @(posedge clk) clr_sync <= rst ? 2'b00 : {clr_sync[0], clr};
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      cursor <= '0;
      last_col <= BLACK;
    end else begin
      state <= nxt;
      cnt <= (state == CLEAR) ? cnt + 1'b1 : '0;
      cursor <= cursor_nxt;
      if (state == DRAW) last_col <= switch;
    end
  always_comb begin
    nxt = state;
    cursor_nxt = cursor;
    if (state == CLEAR && cnt == LAST) begin
      nxt = DRAW;
      cursor_nxt = AW'(0);
    end else if (state == DRAW) nxt = IDLE;
    else if (state == IDLE) begin
      if (clr_sync[1]) nxt = CLEAR;
      else if (r_pls && l_pls) nxt = IDLE;
      else if (r_pls) begin
        nxt = DRAW;
        cursor_nxt = (cursor == LAST) ? AW'(0) : cursor + 1'b1;
      end else if (l_pls) begin
        nxt = DRAW;
        cursor_nxt = (cursor == AW'(0)) ? LAST : cursor - 1'b1;
      end else if (switch != last_col) nxt = DRAW;
    end
  end
  // IDLE feeds the registered port back to itself so addr/data hold
  always_comb begin
    wr_d = state != IDLE;
    addr_d = (state == CLEAR) ? cnt : (state == DRAW) ? cursor : fb.mem_px_addr;
    data_d = (state == CLEAR) ? BLACK : (state == DRAW) ? switch : fb.mem_px_data;
  end
  always_ff @(posedge clk)
    if (rst) begin
      fb.px_wr <= 1'b0;
      fb.mem_px_addr <= '0;
      fb.mem_px_data <= '0;
    end else begin
      fb.px_wr <= wr_d;
      fb.mem_px_addr <= addr_d;
      fb.mem_px_data <= data_d;
    end
endmodule

// File: tb/tb_game_paint_fsm.sv
// tb_game_paint_fsm: randomized actions checked against a write-list model of the painting game
module tb_game_paint_fsm;
  localparam int CELLS = 192;
  logic clk = 1'b0;
  logic rst, in1, in2, clr;
  logic [2:0] sw;
  int checks = 0, failures = 0, cyc = 0;
  int m_cur;
  logic [2:0] m_last;
  logic [10:0] got[$], exp_q[$];
  int gcyc[$];
  always #5 clk = ~clk;
  game_paint_fsm_if fb ();
  game_paint_fsm dut (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .switch(sw), .clr(clr), .fb(fb));
  always @(negedge clk) begin
    cyc++;
    if (fb.px_wr === 1'b1) begin
      got.push_back({fb.mem_px_addr, fb.mem_px_data});
      gcyc.push_back(cyc);
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_w(input int a, input logic [2:0] d);
    exp_q.push_back({a[7:0], d});
  endtask
  task automatic compare(input string tag, input bit consecutive);
    int n;
    check({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, got[i][10:3], exp_q[i][10:3]);
      check({tag, "_data"}, got[i][2:0], exp_q[i][2:0]);
    end
    if (consecutive && n > 1) check({tag, "_burst"}, gcyc[n-1] - gcyc[0], n - 1);
    got.delete();
    exp_q.delete();
    gcyc.delete();
  endtask
  task automatic model_clear();
    for (int a = 0; a < CELLS; a++) expect_w(a, 3'b000);
    m_cur = 0;
    expect_w(0, sw);
    m_last = sw;
  endtask
  task automatic press(input bit r, input bit l);
    in1 = r;
    in2 = l;
    settle(3);
    in1 = 1'b0;
    in2 = 1'b0;
    settle(7);
    if (r && !l) begin
      m_cur = (m_cur + 1) % CELLS;
      expect_w(m_cur, m_last);
    end else if (l && !r) begin
      m_cur = (m_cur + CELLS - 1) % CELLS;
      expect_w(m_cur, m_last);
    end
    compare(r && l ? "both" : r ? "right" : "left", 1'b0);
  endtask
  task automatic colour(input logic [2:0] c);
    sw = c;
    settle(6);
    if (c != m_last) begin
      expect_w(m_cur, c);
      m_last = c;
    end
    compare("colour", 1'b0);
  endtask
  task automatic clear(input bit press_during);
    clr = 1'b1;
    settle(1);
    clr = 1'b0;
    if (press_during) begin
      settle(20);
      in1 = 1'b1;
      settle(5);
      in1 = 1'b0;
      settle(200);
    end else settle(225);
    model_clear();
    compare(press_during ? "clear_press" : "clear", 1'b1);
  endtask
  initial begin
    int n, k;
    rst = 1'b1;
    in1 = 1'b0;
    in2 = 1'b0;
    clr = 1'b0;
    sw = 3'b100;
    settle(3);
    check("rst_wr", fb.px_wr, 0);
    check("rst_addr", fb.mem_px_addr, 0);
    check("rst_data", fb.mem_px_data, 0);
    got.delete();
    gcyc.delete();
    rst = 1'b0;
    settle(210);
    model_clear();
    compare("boot", 1'b1);
    check("boot_idle_wr", fb.px_wr, 0);
    sw = 3'b010;
    settle(6);
    got.delete();
    gcyc.delete();
    m_last = 3'b010;
    n = 0;
    in1 = 1'b1;
    do begin
      @(posedge clk);
      #1 n++;
    end while (fb.px_wr !== 1'b1 && n < 20);
    check("latency", n, 4);
    @(negedge clk);
    in1 = 1'b0;
    settle(6);
    m_cur = 1;
    expect_w(1, 3'b010);
    compare("lat_write", 1'b0);
    check("idle_hold_addr", fb.mem_px_addr, 1);
    check("idle_hold_data", fb.mem_px_data, 3'b010);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    colour(3'b001);
    colour(3'b001);
    for (int i = 0; i < 37; i++) press(1'b1, 1'b0);
    check("cursor37", m_cur, 37);
    clear(1'b0);
    press(1'b1, 1'b1);
    clear(1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 19);
      if (k < 7) press(1'b1, 1'b0);
      else if (k < 13) press(1'b0, 1'b1);
      else if (k < 15) press(1'b1, 1'b1);
      else if (k < 19) colour(3'($urandom_range(0, 7)));
      else clear($urandom_range(0, 1) == 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
